// File: rtl/disp_arb_pkg.sv
// Shared types and helpers for the two-requester seven-segment display arbiter.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;

  // Digit k of a display word; digit 0 is the least significant nibble.
  function automatic logic [DIGIT_W-1:0] word_nibble(
    input logic [NUM_DIGITS*DIGIT_W-1:0] word,
    input int                            k
  );
    return word[k*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// Saturating ownership-tenure counter; done marks that the minimum hold has elapsed.
module hold_timer #(
  parameter int HOLD_CYCLES = 100000,
  localparam int CNT_W      = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  // Count owned cycles; clear on every ownership entry and stick at LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      hold_cnt <= {CNT_W{1'b0}};
    end else if (enable && (hold_cnt != LAST)) begin
      hold_cnt <= hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      hold_cnt <= hold_cnt;
    end
  end

  assign done = (hold_cnt == LAST);

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the 8-digit display between two requesters with round-robin
// tie-break and a minimum hold before a contender may preempt the owner.
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int          HOLD_CYCLES = 100000,
  parameter logic [31:0] IDLE_WORD   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  wr,
  input  logic [31:0] word_0,
  input  logic [31:0] word_1,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [3:0]  data_7,
  output logic [3:0]  data_6,
  output logic [3:0]  data_5,
  output logic [3:0]  data_4,
  output logic [3:0]  data_3,
  output logic [3:0]  data_2,
  output logic [3:0]  data_1,
  output logic [3:0]  data_0
);

  arb_state_t  state;
  arb_state_t  next_state;
  logic [31:0] disp_word;
  logic [31:0] next_word;
  logic        last_owner;
  logic        next_last;
  logic        entry;
  logic        tgt;
  logic        own_idx;
  logic        oth_idx;
  logic        hold_done;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (CLK),
    .rst   (reset),
    .clear (entry),
    .enable(state != IDLE),
    .done  (hold_done)
  );

  // Next-state and next-display-word selection; any ownership entry loads the new owner's word.
  always_comb begin
    next_state = state;
    next_word  = disp_word;
    next_last  = last_owner;
    entry      = 1'b0;
    tgt        = 1'b0;
    own_idx    = (state == OWN1);
    oth_idx    = ~own_idx;
    case (state)
      IDLE: begin
        case (req)
          2'b01: begin
            entry = 1'b1;
            tgt   = 1'b0;
          end
          2'b10: begin
            entry = 1'b1;
            tgt   = 1'b1;
          end
          2'b11: begin
            entry = 1'b1;
            tgt   = ~last_owner;
          end
          default: begin
            entry = 1'b0;
          end
        endcase
      end
      OWN0, OWN1: begin
        if (!req[own_idx] && req[oth_idx]) begin
          entry = 1'b1;
          tgt   = oth_idx;
        end else if (!req[own_idx]) begin
          next_state = IDLE;
          next_word  = IDLE_WORD;
        end else if (req[oth_idx] && hold_done) begin
          entry = 1'b1;
          tgt   = oth_idx;
        end else if (wr[own_idx]) begin
          next_word = own_idx ? word_1 : word_0;
        end else begin
          next_word = disp_word;
        end
      end
      default: begin
        next_state = IDLE;
        next_word  = IDLE_WORD;
      end
    endcase
    if (entry) begin
      next_state = tgt ? OWN1 : OWN0;
      next_word  = tgt ? word_1 : word_0;
      next_last  = tgt;
    end else begin
      next_last  = last_owner;
    end
  end

  // State, ownership outputs and display word, all registered.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      busy       <= 1'b0;
      last_owner <= 1'b1;
      disp_word  <= IDLE_WORD;
    end else begin
      state      <= next_state;
      last_owner <= next_last;
      disp_word  <= next_word;
      case (next_state)
        OWN0:    grant <= 2'b01;
        OWN1:    grant <= 2'b10;
        default: grant <= 2'b00;
      endcase
      busy       <= (next_state != IDLE);
    end
  end

  assign data_7 = word_nibble(disp_word, 7);
  assign data_6 = word_nibble(disp_word, 6);
  assign data_5 = word_nibble(disp_word, 5);
  assign data_4 = word_nibble(disp_word, 4);
  assign data_3 = word_nibble(disp_word, 3);
  assign data_2 = word_nibble(disp_word, 2);
  assign data_1 = word_nibble(disp_word, 1);
  assign data_0 = word_nibble(disp_word, 0);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed and randomized checks of display_arbiter against a tenure-based ownership model.
module tb_display_arbiter;

  localparam int          HOLD = 4;
  localparam logic [31:0] IDLE_W = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] word_0;
  logic [31:0] word_1;
  logic [1:0]  grant;
  logic        busy;
  logic [3:0]  data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0;

  int passed = 0;
  int total  = 0;

  // Reference model: who owns the display, for how many edges, and what is shown.
  int          m_owner;
  int          m_tenure;
  int          m_last;
  logic [31:0] m_shown;

  display_arbiter #(
    .HOLD_CYCLES(HOLD),
    .IDLE_WORD  (IDLE_W)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .req   (req),
    .wr    (wr),
    .word_0(word_0),
    .word_1(word_1),
    .grant (grant),
    .busy  (busy),
    .data_7(data_7),
    .data_6(data_6),
    .data_5(data_5),
    .data_4(data_4),
    .data_3(data_3),
    .data_2(data_2),
    .data_1(data_1),
    .data_0(data_0)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] shown_word();
    return {data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0};
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return (i == 0) ? word_0 : word_1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_tenure = 0;
    m_last   = 1;
    m_shown  = IDLE_W;
  endtask

  task automatic model_enter(input int i);
    m_owner  = i;
    m_tenure = 0;
    m_last   = i;
    m_shown  = word_of(i);
  endtask

  task automatic model_edge();
    int o;
    int p;
    if (m_owner < 0) begin
      if (req == 2'b11)      model_enter(1 - m_last);
      else if (req[0])       model_enter(0);
      else if (req[1])       model_enter(1);
    end else begin
      o = m_owner;
      p = 1 - o;
      if (!req[o]) begin
        if (req[p]) model_enter(p);
        else begin
          m_owner = -1;
          m_shown = IDLE_W;
        end
      end else if (req[p] && m_tenure >= HOLD - 1) begin
        model_enter(p);
      end else begin
        m_tenure++;
        if (wr[o]) m_shown = word_of(o);
      end
    end
  endtask

  function automatic logic [1:0] m_grant();
    return (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_grant"}, {30'd0, grant}, {30'd0, m_grant()});
    check({tag, "_busy"},  {31'd0, busy},  {31'd0, (m_owner >= 0)});
    check({tag, "_data"},  shown_word(),   m_shown);
  endtask

  // One clock edge with the current inputs, then compare DUT to the model.
  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    reset  = 1'b1;
    req    = 2'b00;
    wr     = 2'b00;
    word_0 = 32'h0;
    word_1 = 32'h0;
    model_reset();
    #1;
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_data",  shown_word(),   32'hFFFF_FFFF);
    @(posedge CLK);
    #3;
    reset = 1'b0;

    // Single requester 0, then release.
    req    = 2'b01;
    word_0 = 32'h8765_4321;
    step("own0");
    check("own0_grant_k", {30'd0, grant}, 32'd1);
    check("own0_d7", {28'd0, data_7}, 32'd8);
    check("own0_d0", {28'd0, data_0}, 32'd1);
    req = 2'b00;
    step("rel0");
    check("rel0_data_k", shown_word(), 32'hFFFF_FFFF);

    // Owner writes are honoured; the other requester's strobe is not.
    req = 2'b01;
    step("own0b");
    wr     = 2'b01;
    word_0 = 32'hDEAD_BEEF;
    step("wr0");
    check("wr0_data_k", shown_word(), 32'hDEAD_BEEF);
    wr     = 2'b10;
    word_1 = 32'h1111_1111;
    step("wr1_ignored");
    check("wr1_data_k", shown_word(), 32'hDEAD_BEEF);
    wr = 2'b00;

    // Asynchronous reset in the middle of ownership.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_grant", {30'd0, grant}, 32'd0);
    check("async_rst_busy",  {31'd0, busy},  32'd0);
    check("async_rst_data",  shown_word(),   32'hFFFF_FFFF);
    #2;
    reset = 1'b0;

    // Both requesting from idle: 0 wins first, then alternation every HOLD cycles.
    req    = 2'b11;
    word_0 = 32'hAAAA_0000;
    word_1 = 32'hBBBB_1111;
    step("tie");
    check("tie_first_k", {30'd0, grant}, 32'd1);
    for (int i = 0; i < HOLD; i++) step("alt_a");
    check("alt_to1_k", {30'd0, grant}, 32'd2);
    check("alt_to1_data_k", shown_word(), 32'hBBBB_1111);
    for (int i = 0; i < HOLD; i++) step("alt_b");
    check("alt_to0_k", {30'd0, grant}, 32'd1);

    // Walk to owner 1, then owner 1 drops while 0 still requests: direct handover.
    for (int i = 0; i < HOLD; i++) step("to1");
    check("own1_k", {30'd0, grant}, 32'd2);
    req = 2'b01;
    step("handover");
    check("handover_k", {30'd0, grant}, 32'd1);

    // Sole requester keeps the display indefinitely.
    for (int i = 0; i < 20; i++) begin
      step("sole");
      check("sole_k", {30'd0, grant}, 32'd1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req    = 2'($urandom_range(0, 3));
      wr     = 2'($urandom_range(0, 3));
      word_0 = $urandom;
      word_1 = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
